// File: rtl/fma_issue_queue_pkg.sv
// Shared FP issue types: op encodings, execute status bundle, FMA IQ entry, latencies.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Supplies PREG_WIDTH / FLTOP_WIDTH defaults when the surrounding build does not.
`ifndef PREG_WIDTH
`define PREG_WIDTH 6
`endif
`ifndef FLTOP_WIDTH
`define FLTOP_WIDTH 4
`endif

package fma_issue_queue_pkg;

   localparam int FLTOP_W = `FLTOP_WIDTH;

   // Writeback offsets, in cycles from iss_en to FMA result valid.
   localparam int FMA_LAT_ADD  = 1;
   localparam int FMA_LAT_MUL  = 2;
   localparam int FMA_LAT_MADD = 4;

   // Reservation window: bit k of the post-shift view means the writeback
   // slot k cycles after the current selection cycle is already taken.
   localparam int RESV_W = FMA_LAT_MADD + 1;

   typedef enum logic [FLTOP_W-1:0] {
      FLT_ADD   = FLTOP_W'(0),
      FLT_SUB   = FLTOP_W'(1),
      FLT_MUL   = FLTOP_W'(2),
      FLT_MADD  = FLTOP_W'(3),
      FLT_MSUB  = FLTOP_W'(4),
      FLT_NMADD = FLTOP_W'(5),
      FLT_NMSUB = FLTOP_W'(6)
   } fltop_e;

   // Per-op bookkeeping that travels with the op to the FMA unit.
   typedef struct packed {
      logic [4:0] rob_idx;
      logic [1:0] fmt;
      logic       is_vec;
   } ExStatusBundle;

   // Source tags are held beside this struct in the queue so that the
   // physical tag width can be overridden per instance.
   typedef struct packed {
      logic                valid;
      logic [FLTOP_W-1:0]  op;
      logic [2:0]          rm;
      logic [2:0]          src_rdy;   // rs3, rs2, rs1
      ExStatusBundle       status;
   } FmaIqEntry;

   function automatic logic fma_op_fused(input logic [FLTOP_W-1:0] op);
      return (op == FLT_MADD) || (op == FLT_MSUB) ||
             (op == FLT_NMADD) || (op == FLT_NMSUB);
   endfunction

   // Unknown encodings are treated as single-cycle ops.
   function automatic logic [2:0] fma_op_lat(input logic [FLTOP_W-1:0] op);
      case (op)
         FLT_MUL:                                   return 3'(FMA_LAT_MUL);
         FLT_MADD, FLT_MSUB, FLT_NMADD, FLT_NMSUB:  return 3'(FMA_LAT_MADD);
         default:                                   return 3'(FMA_LAT_ADD);
      endcase
   endfunction

endpackage

// File: rtl/fma_iq_select.sv
// fma_iq_select: picks one eligible queue entry, one-hot grant.
// Latency: combinational grant; the age matrix updates on allocation edges.
// Backpressure: none; grant is zero when nothing is eligible.
// Ports: elig (eligible entries), grant (one-hot winner); with FMA_IQ_AGE_ORDER_EN
//        also clk/rst and alloc (one-hot slot written this cycle) for the age matrix.
// Config: FMA_IQ_AGE_ORDER_EN -> oldest eligible wins; otherwise lowest index wins.
module fma_iq_select
   import fma_issue_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
`ifdef FMA_IQ_AGE_ORDER_EN
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] alloc,
`endif
   input  logic [DEPTH-1:0] elig,
   output logic [DEPTH-1:0] grant
);

`ifdef FMA_IQ_AGE_ORDER_EN
   // older_q[i][j] = entry i was allocated before entry j. A newly written
   // slot becomes younger than everything, so its row clears and its column
   // sets. Stale rows of free slots are harmless: only eligible (valid)
   // entries are ever compared, and every pair of valid entries had its
   // relation refreshed when the younger of the two was written.
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] blocked;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (alloc[i])
                  older_q[i][j] <= 1'b0;
               else if (alloc[j])
                  older_q[i][j] <= (i != j);
            end
         end
      end
   end

   always_comb begin
      blocked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if ((j != i) && elig[j] && older_q[j][i]) blocked[i] = 1'b1;
         end
      end
      grant = elig & ~blocked;
   end
`else
   // Isolate the lowest set bit.
   assign grant = elig & (~elig + DEPTH'(1));
`endif

endmodule

// File: rtl/fma_issue_queue.sv
// fma_issue_queue: FMA issue queue with wakeup tracking and writeback-slot reservation.
// Latency: enqueue to iss_en is 2 cycles minimum (capture, then registered issue).
// Backpressure: enq_ready drops when all DEPTH entries are valid; issue side never stalls.
// Ports: clk, rst (sync, active high); enq_* enqueue channel with per-source ready bits;
//        wakeup_en/wakeup_rd broadcast of W tags becoming ready; iss_* registered issue
//        outputs (fields hold when iss_en=0); flush kills all entries and reservations.
// Config: FMA_IQ_AGE_ORDER_EN -> oldest eligible entry issues first, else lowest index.
`ifndef PREG_WIDTH
`define PREG_WIDTH 6
`endif

module fma_issue_queue
   import fma_issue_queue_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PREG_W = `PREG_WIDTH,
   parameter int W      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enq_valid,
   output logic                         enq_ready,
   input  logic [FLTOP_W-1:0]           enq_op,
   input  logic [2:0]                   enq_rm,
   input  logic [2:0][PREG_W-1:0]       enq_src,
   input  logic [2:0]                   enq_src_rdy,
   input  ExStatusBundle                enq_status,
   input  logic [W-1:0]                 wakeup_en,
   input  logic [W-1:0][PREG_W-1:0]     wakeup_rd,
   output logic                         iss_en,
   output logic [FLTOP_W-1:0]           iss_op,
   output logic [2:0]                   iss_rm,
   output logic [2:0][PREG_W-1:0]       iss_src,
   output ExStatusBundle                iss_status,
   input  logic                         flush
);

   FmaIqEntry [DEPTH-1:0]               ent_q;
   logic [DEPTH-1:0][2:0][PREG_W-1:0]   ent_src_q;
   logic [RESV_W-1:0]                   resv_q;
   logic [RESV_W-1:0]                   resv_shift;

   logic [DEPTH-1:0]                    valid_vec;
   logic [DEPTH-1:0]                    free_vec;
   logic [DEPTH-1:0]                    alloc_oh;
   logic [DEPTH-1:0]                    elig;
   logic [DEPTH-1:0]                    grant;
   logic [DEPTH-1:0][2:0]               wake_hit;
   logic [2:0]                          enq_wake;
   logic                                enq_fire;

   logic                                sel_any;
   logic [FLTOP_W-1:0]                  sel_op;
   logic [2:0]                          sel_rm;
   logic [2:0][PREG_W-1:0]              sel_src;
   ExStatusBundle                       sel_status;
   logic [2:0]                          sel_lat;

   // ---------------------------------------------------------------------
   // Wakeup matching, for resident entries and for the op being enqueued.
   // A wakeup coinciding with enqueue marks the source ready even when
   // enq_src_rdy says otherwise.
   // ---------------------------------------------------------------------
   always_comb begin
      enq_wake = '0;
      wake_hit = '0;
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < W; w++) begin
            if (wakeup_en[w] && (wakeup_rd[w] == enq_src[s])) enq_wake[s] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
               if (wakeup_en[w] && (wakeup_rd[w] == ent_src_q[i][s]))
                  wake_hit[i][s] = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Eligibility. The reservation register is examined after this cycle's
   // shift, so R[L] set means an earlier issue already owns the writeback
   // slot this op would land in. rs3 only matters for the fused ops.
   // ---------------------------------------------------------------------
   assign resv_shift = resv_q >> 1;

   always_comb begin
      valid_vec = '0;
      elig      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = ent_q[i].valid;
         elig[i] = ent_q[i].valid
                   && ent_q[i].src_rdy[0] && ent_q[i].src_rdy[1]
                   && (ent_q[i].src_rdy[2] || !fma_op_fused(ent_q[i].op))
                   && !resv_shift[fma_op_lat(ent_q[i].op)]
                   && !flush && !rst;
      end
   end

   fma_iq_select #(.DEPTH(DEPTH)) u_select (
`ifdef FMA_IQ_AGE_ORDER_EN
      .clk   (clk),
      .rst   (rst),
      .alloc (alloc_oh),
`endif
      .elig  (elig),
      .grant (grant)
   );

   // ---------------------------------------------------------------------
   // Allocation. enq_ready looks only at current occupancy, so a full queue
   // refuses an enqueue even while an entry is issuing that same cycle.
   // The slot being issued is still valid here and therefore never reused
   // in the same cycle.
   // ---------------------------------------------------------------------
   assign enq_ready = ~&valid_vec;
   assign free_vec  = ~valid_vec;
   assign enq_fire  = enq_valid && enq_ready && !flush && !rst;
   assign alloc_oh  = enq_fire ? (free_vec & (~free_vec + DEPTH'(1))) : '0;

   // Grant is one-hot, so OR-ing the masked fields is a plain mux.
   always_comb begin
      sel_any    = |grant;
      sel_op     = '0;
      sel_rm     = '0;
      sel_src    = '0;
      sel_status = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            sel_op     = sel_op | ent_q[i].op;
            sel_rm     = sel_rm | ent_q[i].rm;
            sel_src    = sel_src | ent_src_q[i];
            sel_status = sel_status | ent_q[i].status;
         end
      end
      sel_lat = fma_op_lat(sel_op);
   end

   // ---------------------------------------------------------------------
   // Queue state, reservation register and issue valid.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
         resv_q <= '0;
         iss_en <= 1'b0;
      end else begin
         resv_q <= resv_shift | (sel_any ? (RESV_W'(1) << sel_lat) : '0);
         iss_en <= sel_any;
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) begin
               ent_q[i].valid   <= 1'b1;
               ent_q[i].op      <= enq_op;
               ent_q[i].rm      <= enq_rm;
               ent_q[i].src_rdy <= enq_src_rdy | enq_wake;
               ent_q[i].status  <= enq_status;
               ent_src_q[i]     <= enq_src;
            end else begin
               if (grant[i]) ent_q[i].valid <= 1'b0;
               ent_q[i].src_rdy <= ent_q[i].src_rdy | wake_hit[i];
            end
         end
      end
   end

   // Issue payload only moves on a real selection and otherwise holds.
   always_ff @(posedge clk) begin
      if (sel_any) begin
         iss_op     <= sel_op;
         iss_rm     <= sel_rm;
         iss_src    <= sel_src;
         iss_status <= sel_status;
      end
   end

endmodule

// File: tb/tb_fma_issue_queue.sv
module tb_fma_issue_queue;
   import fma_issue_queue_pkg::*;

   localparam int DEPTH  = 8;
   localparam int PREG_W = 6;
   localparam int W      = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enq_valid;
   logic                     enq_ready;
   logic [FLTOP_W-1:0]       enq_op;
   logic [2:0]               enq_rm;
   logic [2:0][PREG_W-1:0]   enq_src;
   logic [2:0]               enq_src_rdy;
   ExStatusBundle            enq_status;
   logic [W-1:0]             wakeup_en;
   logic [W-1:0][PREG_W-1:0] wakeup_rd;
   logic                     iss_en;
   logic [FLTOP_W-1:0]       iss_op;
   logic [2:0]               iss_rm;
   logic [2:0][PREG_W-1:0]   iss_src;
   ExStatusBundle            iss_status;
   logic                     flush;

   fma_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .enq_valid   (enq_valid),
      .enq_ready   (enq_ready),
      .enq_op      (enq_op),
      .enq_rm      (enq_rm),
      .enq_src     (enq_src),
      .enq_src_rdy (enq_src_rdy),
      .enq_status  (enq_status),
      .wakeup_en   (wakeup_en),
      .wakeup_rd   (wakeup_rd),
      .iss_en      (iss_en),
      .iss_op      (iss_op),
      .iss_rm      (iss_rm),
      .iss_src     (iss_src),
      .iss_status  (iss_status),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: a bag of entries with an allocation sequence number
   // for age, and a set of absolute cycle numbers whose writeback slot is
   // already booked.
   // ---------------------------------------------------------------------
   bit                      m_vld [DEPTH];
   logic [FLTOP_W-1:0]      m_op  [DEPTH];
   logic [2:0]              m_rm  [DEPTH];
   logic [2:0][PREG_W-1:0]  m_src [DEPTH];
   bit   [2:0]              m_rdy [DEPTH];
   ExStatusBundle           m_st  [DEPTH];
   int                      m_seq [DEPTH];
   bit                      booked [int];
   int                      cyc = 0;
   int                      seq_ctr = 0;

   bit                      e_iss = 1'b0;
   logic [FLTOP_W-1:0]      e_op;
   logic [2:0]              e_rm;
   logic [2:0][PREG_W-1:0]  e_src;
   ExStatusBundle           e_st;

   function automatic int lat_of(input logic [FLTOP_W-1:0] op);
      if (op == FLT_ADD || op == FLT_SUB) return 1;
      if (op == FLT_MUL) return 2;
      return 4;
   endfunction

   function automatic bit is_fused(input logic [FLTOP_W-1:0] op);
      return op == FLT_MADD || op == FLT_MSUB || op == FLT_NMADD || op == FLT_NMSUB;
   endfunction

   function automatic bit woken(input logic [PREG_W-1:0] t);
      for (int w = 0; w < W; w++)
         if (wakeup_en[w] && wakeup_rd[w] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_elig(input int i);
      if (!m_vld[i]) return 1'b0;
      if (!m_rdy[i][0] || !m_rdy[i][1]) return 1'b0;
      if (is_fused(m_op[i]) && !m_rdy[i][2]) return 1'b0;
      return !booked.exists(cyc + lat_of(m_op[i]));
   endfunction

   // One clock: compare outputs mid-cycle, advance the model with the inputs
   // currently driven, then move to just after the next rising edge.
   task automatic step();
      int cnt;
      int sel;
      int alloc;
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += m_vld[i];
      check_val("enq_ready", enq_ready, (cnt < DEPTH) ? 1 : 0);
      check_val("iss_en", iss_en, e_iss);
      if (e_iss) begin
         check_val("iss_op", iss_op, e_op);
         check_val("iss_rm", iss_rm, e_rm);
         check_val("iss_src", iss_src, e_src);
         check_val("iss_status", iss_status, e_st);
      end
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
         booked.delete();
         e_iss = 1'b0;
      end else begin
         alloc = -1;
         if (enq_valid && cnt < DEPTH)
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) alloc = i;
         sel = -1;
         for (int i = 0; i < DEPTH; i++) begin
            if (m_elig(i)) begin
`ifdef FMA_IQ_AGE_ORDER_EN
               if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
               if (sel < 0) sel = i;
`endif
            end
         end
         e_iss = (sel >= 0);
         if (sel >= 0) begin
            e_op  = m_op[sel];
            e_rm  = m_rm[sel];
            e_src = m_src[sel];
            e_st  = m_st[sel];
            m_vld[sel] = 1'b0;
            booked[cyc + lat_of(m_op[sel])] = 1'b1;
         end
         for (int i = 0; i < DEPTH; i++)
            for (int s = 0; s < 3; s++)
               if (m_vld[i] && woken(m_src[i][s])) m_rdy[i][s] = 1'b1;
         if (alloc >= 0) begin
            m_vld[alloc] = 1'b1;
            m_op[alloc]  = enq_op;
            m_rm[alloc]  = enq_rm;
            m_src[alloc] = enq_src;
            m_st[alloc]  = enq_status;
            m_seq[alloc] = seq_ctr++;
            for (int s = 0; s < 3; s++) m_rdy[alloc][s] = enq_src_rdy[s] | woken(enq_src[s]);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst       = 1'b0;
      flush     = 1'b0;
      enq_valid = 1'b0;
      wakeup_en = '0;
   endtask

   task automatic set_enq(input logic [FLTOP_W-1:0] op, input int t0, input int t1,
                          input int t2, input logic [2:0] rdy);
      logic [$bits(ExStatusBundle)-1:0] st;
      st          = $bits(ExStatusBundle)'($urandom);
      enq_valid   = 1'b1;
      enq_op      = op;
      enq_rm      = 3'($urandom);
      enq_src[0]  = PREG_W'(t0);
      enq_src[1]  = PREG_W'(t1);
      enq_src[2]  = PREG_W'(t2);
      enq_src_rdy = rdy;
      enq_status  = ExStatusBundle'(st);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         idle_inputs();
         step();
      end
   endtask

   function automatic logic [FLTOP_W-1:0] rand_op();
      case ($urandom_range(0, 6))
         0: return FLT_ADD;
         1: return FLT_SUB;
         2: return FLT_MUL;
         3: return FLT_MADD;
         4: return FLT_MSUB;
         5: return FLT_NMADD;
         default: return FLT_NMSUB;
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PREG_W-1:0] first_tag;
      logic [PREG_W-1:0] second_tag;
      logic [2:0]        rr;

      enq_op = '0; enq_rm = '0; enq_src = '0; enq_src_rdy = '0; enq_status = '0;
      wakeup_rd = '0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      idle_inputs();
      step();
      check_val("rst_iss_en", iss_en, 0);
      check_val("rst_enq_ready", enq_ready, 1);

      // ADD with all sources ready: iss_en two cycles after the enqueue.
      set_enq(FLT_ADD, 1, 2, 3, 3'b111);
      step();
      check_val("add_lat_c1", iss_en, 0);
      idle_inputs();
      step();
      check_val("add_lat_c2", iss_en, 1);
      check_val("add_lat_op", iss_op, FLT_ADD);
      drain(6);

      // MADD books slot s+4; an ADD eligible at s+3 must slip to s+4.
      set_enq(FLT_MADD, 1, 2, 3, 3'b111);
      step();
      idle_inputs();
      step();
      check_val("madd_iss", iss_en, 1);
      check_val("madd_op", iss_op, FLT_MADD);
      step();
      set_enq(FLT_ADD, 4, 5, 6, 3'b111);
      step();
      idle_inputs();
      step();
      check_val("add_blocked", iss_en, 0);
      step();
      check_val("add_delayed", iss_en, 1);
      check_val("add_delayed_op", iss_op, FLT_ADD);
      drain(6);

      // Fill with unready rs1 tags; slot 3 waits on tag 5.
      for (int i = 0; i < DEPTH; i++) begin
         set_enq(FLT_ADD, (i == 3) ? 5 : 32 + i, 1, 1, 3'b110);
         step();
      end
      idle_inputs();
      check_val("full_enq_ready", enq_ready, 0);
      set_enq(FLT_ADD, 1, 1, 1, 3'b111);
      wakeup_en[0] = 1'b1;
      wakeup_rd[0] = PREG_W'(5);
      step();
      idle_inputs();
      step();
      check_val("wake5_iss", iss_en, 1);
      check_val("wake5_src", iss_src[0], 5);
      check_val("wake5_ready", enq_ready, 1);
      flush = 1'b1;
      step();
      drain(6);

      // Wakeup in the enqueue cycle overrides an unready rs1.
      set_enq(FLT_ADD, 9, 2, 3, 3'b110);
      wakeup_en[0] = 1'b1;
      wakeup_rd[0] = PREG_W'(9);
      step();
      idle_inputs();
      step();
      check_val("enq_wake_iss", iss_en, 1);
      check_val("enq_wake_src", iss_src[0], 9);
      drain(6);

      // Flush with four waiting entries and a MADD in flight.
      for (int i = 0; i < 4; i++) begin
         set_enq(FLT_ADD, 40 + i, 1, 1, 3'b110);
         step();
      end
      set_enq(FLT_MADD, 1, 2, 3, 3'b111);
      step();
      idle_inputs();
      step();
      check_val("fl_madd_iss", iss_en, 1);
      flush = 1'b1;
      set_enq(FLT_ADD, 1, 2, 3, 3'b111);
      step();
      idle_inputs();
      check_val("fl_iss_off", iss_en, 0);
      set_enq(FLT_ADD, 7, 8, 9, 3'b111);
      step();
      idle_inputs();
      check_val("fl_drop_enq", iss_en, 0);
      step();
      check_val("fl_add_nodelay", iss_en, 1);
      check_val("fl_add_op", iss_op, FLT_ADD);
      wakeup_en = '1;
      wakeup_rd[0] = PREG_W'(40);
      wakeup_rd[1] = PREG_W'(41);
      step();
      idle_inputs();
      step();
      step();
      check_val("fl_killed", iss_en, 0);
      drain(4);

      // Slot 3 older than slot 1, both become ready together.
      for (int i = 0; i < 4; i++) begin
         set_enq(FLT_ADD, 20 + i, 1, 1, 3'b110);
         step();
      end
      idle_inputs();
      wakeup_en[0] = 1'b1;
      wakeup_rd[0] = PREG_W'(21);
      step();
      idle_inputs();
      step();
      set_enq(FLT_ADD, 24, 1, 1, 3'b110);
      step();
      idle_inputs();
      wakeup_en = '1;
      wakeup_rd[0] = PREG_W'(23);
      wakeup_rd[1] = PREG_W'(24);
      step();
      idle_inputs();
      step();
`ifdef FMA_IQ_AGE_ORDER_EN
      first_tag = PREG_W'(23);
      second_tag = PREG_W'(24);
`else
      first_tag = PREG_W'(24);
      second_tag = PREG_W'(23);
`endif
      check_val("order_first_en", iss_en, 1);
      check_val("order_first", iss_src[0], first_tag);
      step();
      check_val("order_second_en", iss_en, 1);
      check_val("order_second", iss_src[0], second_tag);
      flush = 1'b1;
      step();
      drain(6);

      // Reset during the selection cycle discards the entry.
      set_enq(FLT_ADD, 1, 2, 3, 3'b111);
      step();
      idle_inputs();
      rst = 1'b1;
      step();
      idle_inputs();
      check_val("midrst_iss", iss_en, 0);
      check_val("midrst_ready", enq_ready, 1);
      drain(4);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         if ($urandom_range(0, 99) < 45) begin
            for (int s = 0; s < 3; s++) rr[s] = ($urandom_range(0, 99) < 60);
            set_enq(rand_op(), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), rr);
         end
         for (int w = 0; w < W; w++) begin
            wakeup_en[w] = ($urandom_range(0, 99) < 30);
            wakeup_rd[w] = PREG_W'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 199) == 0) flush = 1'b1;
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         step();
      end
      drain(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
